rsa_host: RTL and testbench

RSA_HOST -- requirements
Module: rsa_host

---
 rtl/rsa_host_pkg.sv | 31 +++
 rtl/rsa_host.sv | 167 ++++++++++++++++
 tb/tb_rsa_host.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_host_pkg.sv
// Shared definitions for the RSA core host sequencer: FSM states, core
// register-select codes and the default operand width.
package rsa_host_pkg;

    localparam int NBYTES_DEF = 32;

    typedef enum logic [2:0] {
        ST_LOAD      = 3'd0,
        ST_PRECOMP   = 3'd1,
        ST_RUN_RISE  = 3'd2,
        ST_RUN_FALL  = 3'd3,
        ST_READ_REQ  = 3'd4,
        ST_READ_WAIT = 3'd5,
        ST_SEND      = 3'd6
    } state_t;

    localparam logic [1:0] SEL_RES = 2'd0;
    localparam logic [1:0] SEL_MSG = 2'd1;
    localparam logic [1:0] SEL_EXP = 2'd2;
    localparam logic [1:0] SEL_MOD = 2'd3;

    // Operands arrive as modulus, then message, then exponent.
    function automatic logic [1:0] next_load_sel(input logic [1:0] sel);
        case (sel)
            SEL_MOD: next_load_sel = SEL_MSG;
            SEL_MSG: next_load_sel = SEL_EXP;
            default: next_load_sel = SEL_MOD;
        endcase
    endfunction

endpackage

// File: rtl/rsa_host.sv
// Byte-stream host for an RSA exponentiation core: loads modulus, message and
// exponent, runs the core with a timeout, then streams the result LSB first.
module rsa_host
    import rsa_host_pkg::*;
#(
    parameter int NBYTES         = NBYTES_DEF,
    parameter int PRECOMP_CYCLES = 520,
    parameter int TIMEOUT        = 1048576
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       err,
    output logic       core_we_n,
    output logic       core_oe_n,
    output logic [1:0] core_reg_sel,
    output logic [5:0] core_addr,
    output logic [7:0] core_wdata,
    input  logic [7:0] core_rdata,
    output logic       core_start,
    input  logic       core_busy
);

    localparam logic [5:0]  LAST_IDX = 6'(NBYTES - 1);
    localparam logic [20:0] PRE_LAST = 21'(PRECOMP_CYCLES - 1);
    localparam logic [20:0] TO_LAST  = 21'(TIMEOUT - 1);

    state_t      r_state;
    logic [5:0]  r_idx;
    logic [1:0]  r_load_sel;
    logic [5:0]  r_res;
    logic [20:0] r_cnt;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [7:0]  r_out_data;
    logic        r_err;
    logic        r_we_n;
    logic        r_oe_n;
    logic [1:0]  r_sel;
    logic [5:0]  r_addr;
    logic [7:0]  r_wdata;
    logic        r_start;

    // NOTE: all state uses non-blocking assignment so every register samples
    // pre-edge values; the reset branch is inside the clocked block (synchronous).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_LOAD;
            r_idx       <= '0;
            r_load_sel  <= SEL_MOD;
            r_res       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_err       <= 1'b0;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_sel       <= SEL_RES;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_start     <= 1'b0;
        end else begin
            // Strobes and err are single-cycle pulses unless re-armed below.
            r_we_n <= 1'b1;
            r_oe_n <= 1'b1;
            r_err  <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    if (in_valid && r_in_ready) begin
                        r_we_n  <= 1'b0;
                        r_sel   <= r_load_sel;
                        r_addr  <= r_idx;
                        r_wdata <= in_data;
                        if (r_idx == LAST_IDX) begin
                            r_idx <= '0;
                            if (r_load_sel == SEL_EXP) begin
                                r_load_sel <= SEL_MOD;
                                r_in_ready <= 1'b0;
                                r_cnt      <= '0;
                                r_state    <= ST_PRECOMP;
                            end else begin
                                r_load_sel <= next_load_sel(r_load_sel);
                            end
                        end else begin
                            r_idx <= r_idx + 6'd1;
                        end
                    end
                end
                ST_PRECOMP: begin
                    if (r_cnt == PRE_LAST) begin
                        r_start <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_RUN_RISE;
                    end else begin
                        r_cnt <= r_cnt + 21'd1;
                    end
                end
                ST_RUN_RISE, ST_RUN_FALL: begin
                    if (r_cnt == TO_LAST) begin
                        r_err      <= 1'b1;
                        r_start    <= 1'b0;
                        r_cnt      <= '0;
                        r_idx      <= '0;
                        r_load_sel <= SEL_MOD;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_LOAD;
                    end else begin
                        r_cnt <= r_cnt + 21'd1;
                        if (r_state == ST_RUN_RISE && core_busy) begin
                            r_state <= ST_RUN_FALL;
                        end else if (r_state == ST_RUN_FALL && !core_busy) begin
                            r_start <= 1'b0;
                            r_res   <= '0;
                            r_oe_n  <= 1'b0;
                            r_sel   <= SEL_RES;
                            r_addr  <= '0;
                            r_state <= ST_READ_REQ;
                        end
                    end
                end
                ST_READ_REQ: r_state <= ST_READ_WAIT;
                ST_READ_WAIT: begin
                    r_out_data  <= core_rdata;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (r_res == LAST_IDX) begin
                            r_res      <= '0;
                            r_idx      <= '0;
                            r_load_sel <= SEL_MOD;
                            r_in_ready <= 1'b1;
                            r_state    <= ST_LOAD;
                        end else begin
                            r_res   <= r_res + 6'd1;
                            r_oe_n  <= 1'b0;
                            r_sel   <= SEL_RES;
                            r_addr  <= r_res + 6'd1;
                            r_state <= ST_READ_REQ;
                        end
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign err          = r_err;
    assign core_we_n    = r_we_n;
    assign core_oe_n    = r_oe_n;
    assign core_reg_sel = r_sel;
    assign core_addr    = r_addr;
    assign core_wdata   = r_wdata;
    assign core_start   = r_start;

endmodule

// File: tb/tb_rsa_host.sv
// Scoreboard bench for rsa_host: expected core writes and result bytes are
// queued by the stimulus and consumed by a negedge monitor.
module tb_rsa_host;

    localparam int NB  = 32;
    localparam int PRE = 520;
    localparam int TO  = 3000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       err;
    logic       core_we_n;
    logic       core_oe_n;
    logic [1:0] core_reg_sel;
    logic [5:0] core_addr;
    logic [7:0] core_wdata;
    logic [7:0] core_rdata = '0;
    logic       core_start;
    logic       core_busy = 1'b0;

    rsa_host #(.NBYTES(NB), .PRECOMP_CYCLES(PRE), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .err(err),
        .core_we_n(core_we_n), .core_oe_n(core_oe_n), .core_reg_sel(core_reg_sel),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
        .core_start(core_start), .core_busy(core_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [15:0] wr_q[$];
    logic [7:0]  res_q[$];
    bit          wr_en = 1'b1;
    bit          hang = 1'b0;

    int strobes = 0, oe_cnt = 0, outv_cnt = 0, err_cnt = 0;
    int last_strobe_cyc = 0, start_rise_cyc = 0, err_cyc = 0;
    logic start_at_err = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: byte-addressed operand registers, registered read port,
    // busy window after start, result = msg^exp mod mod on the low 32 bits.
    logic [7:0] core_mem [4][NB];
    logic [7:0] res_mem [NB];
    int         bcnt = 0;

    function automatic longint unsigned word_of(input int sel);
        longint unsigned w = 0;
        for (int i = 3; i >= 0; i--) w = (w << 8) | longint'(core_mem[sel][i]);
        return w;
    endfunction

    function automatic longint unsigned modexp(input longint unsigned b,
                                               input longint unsigned e,
                                               input longint unsigned m);
        longint unsigned r = 1;
        if (m == 0) return 0;
        b = b % m;
        while (e != 0) begin
            if (e[0]) r = (r * b) % m;
            b = (b * b) % m;
            e = e >> 1;
        end
        return r % m;
    endfunction

    initial begin
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < NB; i++) core_mem[s][i] = '0;
        for (int i = 0; i < NB; i++) res_mem[i] = '0;
    end

    always @(posedge clk) begin
        if (!core_we_n) core_mem[core_reg_sel][core_addr[4:0]] <= core_wdata;
        if (!core_oe_n) core_rdata <= res_mem[core_addr[4:0]];
        if (!core_start) begin
            bcnt      <= 0;
            core_busy <= 1'b0;
        end else begin
            if (bcnt < 40) bcnt <= bcnt + 1;
            core_busy <= hang ? (bcnt >= 3) : (bcnt >= 3 && bcnt < 25);
            if (bcnt == 10) begin
                for (int i = 0; i < NB; i++)
                    res_mem[i] <= (i < 8) ? 8'(modexp(word_of(1), word_of(2), word_of(3)) >> (8 * i)) : 8'h00;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic prev_start = 1'b0;
        logic [15:0] exp_w;
        logic [7:0]  exp_r;
        forever begin
            @(negedge clk);
            if (!core_we_n) begin
                strobes++;
                last_strobe_cyc = cyc;
                if (wr_en) begin
                    if (wr_q.size() == 0) check("unexpected_write", {core_reg_sel, core_addr, core_wdata}, 16'hFFFF);
                    else begin
                        exp_w = wr_q.pop_front();
                        check("core_write", {core_reg_sel, core_addr, core_wdata}, exp_w);
                    end
                end
            end
            if (!core_oe_n) begin
                oe_cnt++;
                check("oe_excl", {core_we_n, core_reg_sel}, 3'b100);
            end
            if (core_start && !prev_start) start_rise_cyc = cyc;
            prev_start = core_start;
            if (out_valid) outv_cnt++;
            if (out_valid && out_ready) begin
                if (res_q.size() == 0) check("unexpected_result", out_data, 8'hFF);
                else begin
                    exp_r = res_q.pop_front();
                    check("result_byte", out_data, exp_r);
                end
            end
            if (err) begin
                err_cnt++;
                err_cyc = cyc;
                start_at_err = core_start;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_write(input int b);
        int op = b / NB;
        int idx = b % NB;
        logic [1:0] sel = (op == 0) ? 2'd3 : (op == 1) ? 2'd1 : 2'd2;
        logic [7:0] v = '0;
        if (idx == 0) v = (op == 0) ? 8'd221 : (op == 1) ? 8'd5 : 8'd3;
        return {sel, 6'(idx), v};
    endfunction

    task automatic send_bytes(input int count, input bit toggle, input bit expect_wr);
        logic [15:0] w;
        bit ok;
        for (int b = 0; b < count; b++) begin
            w = exp_write(b);
            if (expect_wr) wr_q.push_back(w);
            in_valid = 1'b1;
            in_data  = w[7:0];
            ok = 1'b0;
            for (int n = 0; n < 100 && !ok; n++) begin
                ok = in_ready;
                tick();
            end
            if (!ok) check("in_ready_bound", 32'd0, 32'd1);
            if (toggle) begin
                in_valid = 1'b0;
                tick();
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic push_results();
        res_q.push_back(8'h7D);
        for (int i = 1; i < NB; i++) res_q.push_back(8'h00);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((res_q.size() != 0 || !in_ready) && n < 5000) begin
            tick();
            n++;
        end
        check(name, 32'(n < 5000), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_err", err, 0);
        check("rst_we_n", core_we_n, 1);
        check("rst_oe_n", core_oe_n, 1);
        check("rst_start", core_start, 0);
        check("rst_sel", core_reg_sel, 0);
        check("rst_addr", core_addr, 0);
        check("rst_wdata", core_wdata, 0);
        reset = 1'b0;
        tick();
        check("rst_release_in_ready", in_ready, 1);
    endtask

    task automatic full_run(input string name, input bit toggle);
        int s0 = strobes;
        push_results();
        send_bytes(3 * NB, toggle, 1'b1);
        wait_done({name, "_done"});
        check({name, "_strobes"}, strobes - s0, 3 * NB);
        check({name, "_precomp"}, start_rise_cyc - last_strobe_cyc, PRE);
        check({name, "_wr_drained"}, wr_q.size(), 0);
    endtask

    initial begin
        int n, o0, e0, v0;
        do_reset();

        full_run("basic", 1'b0);
        full_run("toggle", 1'b1);

        // Back-pressure on the first result byte.
        out_ready = 1'b0;
        push_results();
        send_bytes(3 * NB, 1'b0, 1'b1);
        n = 0;
        while (!out_valid && n < 2000) begin tick(); n++; end
        check("bp_valid_bound", 32'(n < 2000), 32'd1);
        o0 = oe_cnt;
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, 8'h7D);
            tick();
        end
        check("bp_no_extra_oe", oe_cnt - o0, 0);
        out_ready = 1'b1;
        wait_done("bp_done");

        // Reset in the middle of a load abandons it.
        wr_en = 1'b0;
        send_bytes(40, 1'b0, 1'b0);
        do_reset();
        wr_q.delete();
        wr_en = 1'b1;
        full_run("after_rst", 1'b0);

        // Core never finishes: timeout path.
        hang = 1'b1;
        e0 = err_cnt;
        v0 = outv_cnt;
        send_bytes(3 * NB, 1'b0, 1'b1);
        n = 0;
        while (err_cnt == e0 && n < 6000) begin tick(); n++; end
        check("to_err_bound", 32'(n < 6000), 32'd1);
        check("to_err_cycle", err_cyc - start_rise_cyc, TO);
        check("to_start_dropped", start_at_err, 0);
        check("to_err_one_cycle", err, 0);
        check("to_in_ready", in_ready, 1);
        hang = 1'b0;
        repeat (5) tick();
        check("to_err_count", err_cnt - e0, 1);
        check("to_no_results", outv_cnt - v0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
